// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port, read-first block RAM among
// NUM_REQ requesters; responses return two cycles after acceptance.
module bram_arbiter #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 11,
    parameter int NUM_REQ       = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [RAM_WIDTH-1:0]             rsp_rdata,
    output logic                             ram_enable,
    output logic                             write_enable,
    output logic [RAM_ADDR_BITS-1:0]         address,
    output logic [RAM_WIDTH-1:0]             input_data,
    input  logic [RAM_WIDTH-1:0]             output_data
);

    localparam int PTR_BITS = $clog2(NUM_REQ);
    localparam logic [PTR_BITS-1:0] LAST_ID = PTR_BITS'(NUM_REQ - 1);

    logic [RAM_ADDR_BITS-1:0] addr_slice  [NUM_REQ];
    logic [RAM_WIDTH-1:0]     wdata_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_slice[gi]  = req_addr[gi*RAM_ADDR_BITS +: RAM_ADDR_BITS];
            assign wdata_slice[gi] = req_wdata[gi*RAM_WIDTH +: RAM_WIDTH];
        end
    endgenerate

    logic [PTR_BITS-1:0]      ptr_reg;
    logic [PTR_BITS-1:0]      ptr_next;
    logic [PTR_BITS-1:0]      grant_id;
    logic [PTR_BITS-1:0]      cand;
    logic                     grant_found;
    logic                     accept;
    logic                     ram_enable_reg;
    logic                     write_enable_reg;
    logic [RAM_ADDR_BITS-1:0] address_reg;
    logic [RAM_WIDTH-1:0]     input_data_reg;
    logic                     tag_s1_valid_reg;
    logic [PTR_BITS-1:0]      tag_s1_reg;
    logic [NUM_REQ-1:0]       rsp_valid_reg;
    logic [NUM_REQ-1:0]       rsp_valid_next;

    // Scan from the priority pointer, wrapping, and take the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_BITS'((int'(ptr_reg) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign accept   = grant_found && !reset;
    assign ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_next = '0;
        if (tag_s1_valid_reg) begin
            rsp_valid_next[tag_s1_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg          <= '0;
            ram_enable_reg   <= 1'b0;
            write_enable_reg <= 1'b0;
            address_reg      <= '0;
            input_data_reg   <= '0;
            tag_s1_valid_reg <= 1'b0;
            tag_s1_reg       <= '0;
            rsp_valid_reg    <= '0;
        end else begin
            ram_enable_reg   <= accept;
            write_enable_reg <= accept && req_write[grant_id];
            tag_s1_valid_reg <= accept;
            tag_s1_reg       <= grant_id;
            // The tag reaches this stage on the same edge the RAM presents read data.
            rsp_valid_reg    <= rsp_valid_next;
            if (accept) begin
                ptr_reg        <= ptr_next;
                address_reg    <= addr_slice[grant_id];
                input_data_reg <= wdata_slice[grant_id];
            end
        end
    end

    assign ram_enable   = ram_enable_reg;
    assign write_enable = write_enable_reg;
    assign address      = address_reg;
    assign input_data   = input_data_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = output_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a read-first RAM model and a response
// scoreboard; expected grants and data come from a reference pointer and shadow memory.
module tb_bram_arbiter;

    localparam int W = 8;
    localparam int A = 11;
    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_write = '0;
    logic [N*A-1:0] req_addr = '0;
    logic [N*W-1:0] req_wdata = '0;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_rdata;
    logic           ram_enable;
    logic           write_enable;
    logic [A-1:0]   address;
    logic [W-1:0]   input_data;
    logic [W-1:0]   output_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ptr_m    = 0;

    logic [W-1:0] mem    [1<<A];
    logic [W-1:0] shadow [1<<A];

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .NUM_REQ(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .address      (address),
        .input_data   (input_data),
        .output_data  (output_data)
    );

    // Read-first single-port RAM with one-cycle read latency
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            for (int i = 0; i < (1 << A); i++) mem[i] <= '0;
            output_data <= '0;
        end else if (ram_enable) begin
            if (write_enable) mem[address] <= input_data;
            output_data <= mem[address];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                check("rsp_cycle", 32'(cyc), 32'(e.due));
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                $display("rsp id=%0d rdata=%02h expected=%02h", e.id, rsp_rdata, e.data);
            end
        end
    end

    task automatic set_cmd(input int id, input logic wr, input logic [A-1:0] ad, input logic [W-1:0] d);
        req_write[id[1:0]]  = wr;
        req_addr[id*A +: A] = ad;
        req_wdata[id*W +: W] = d;
    endtask

    // Drive one cycle of requests, predict the grant, then check the issued RAM command.
    task automatic cycle(input logic [N-1:0] valid);
        int           g;
        int           idx;
        int           a;
        logic [N-1:0] exp_ready;
        logic [W-1:0] wd;
        logic         wr;
        req_valid = valid;
        #1;
        g = -1;
        a = 0;
        wd = '0;
        wr = 1'b0;
        exp_ready = '0;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (g < 0 && valid[idx[1:0]]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g[1:0]] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (g >= 0) begin
            a  = int'(req_addr[g*A +: A]);
            wd = req_wdata[g*W +: W];
            wr = req_write[g[1:0]];
            sb.push_back('{g, shadow[a], cyc + 2});
            if (wr) shadow[a] = wd;
            ptr_m = (g + 1) % N;
            $display("grant id=%0d write=%0b addr=%03h wdata=%02h", g, wr, a, wd);
        end
        @(negedge clock);
        check("ram_enable", 32'(ram_enable), 32'(g >= 0));
        if (g >= 0) begin
            check("address", 32'(address), 32'(a));
            check("write_enable", 32'(write_enable), 32'(wr));
            if (wr) check("input_data", 32'(input_data), 32'(wd));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '1;
        sb.delete();
        foreach (shadow[i]) shadow[i] = '0;
        ptr_m = 0;
        @(negedge clock);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        check("reset_ram_enable", 32'(ram_enable), 32'd0);
        check("reset_write_enable", 32'(write_enable), 32'd0);
        check("reset_address", 32'(address), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        reset = 1'b0;
        $display("reset released");
    endtask

    initial begin
        do_reset();

        // Pointer after reset: 2 then 3, then 2 alone immediately
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 11'(i), 8'h00);
        cycle(4'b1100);
        cycle(4'b1100);
        cycle(4'b0100);

        // Write then read from requester 1
        set_cmd(1, 1'b1, 11'h010, 8'hA5);
        cycle(4'b0010);
        set_cmd(1, 1'b0, 11'h010, 8'h00);
        cycle(4'b0010);
        cycle(4'b0000);
        cycle(4'b0000);

        // Round-robin: writes on the first lap, reads of the same cells on the second
        do_reset();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 11'(12'h100 + i), 8'(8'h50 + i));
        for (int s = 0; s < 4; s++) cycle(4'b1111);
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 11'(12'h100 + i), 8'h00);
        for (int s = 0; s < 4; s++) cycle(4'b1111);
        cycle(4'b0000);
        cycle(4'b0000);

        // Back-to-back hazard: read right after a write to the same address
        set_cmd(0, 1'b1, 11'h7FF, 8'h3C);
        set_cmd(3, 1'b0, 11'h7FF, 8'h00);
        cycle(4'b0001);
        cycle(4'b1000);
        cycle(4'b0000);
        cycle(4'b0000);

        // Write response returns old contents
        set_cmd(2, 1'b1, 11'h005, 8'h11);
        cycle(4'b0100);
        set_cmd(2, 1'b1, 11'h005, 8'h22);
        cycle(4'b0100);
        set_cmd(2, 1'b0, 11'h005, 8'h00);
        cycle(4'b0100);
        cycle(4'b0000);
        cycle(4'b0000);

        // Reset mid-flight: the accepted read never responds
        set_cmd(0, 1'b0, 11'h010, 8'h00);
        cycle(4'b0001);
        do_reset();
        check("midflight_rsp_valid", 32'(rsp_valid), 32'd0);
        set_cmd(1, 1'b0, 11'h020, 8'h00);
        set_cmd(2, 1'b0, 11'h021, 8'h00);
        cycle(4'b0110);
        cycle(4'b0000);
        cycle(4'b0000);
        cycle(4'b0000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
